// File: rtl/serial_tx_controller_if.sv
// Memory-controller and interrupt-controller bus shared by serial_tx_controller.
// Handshake: the master raises MEMC_RAM_ENABLE for exactly one cycle per access and every access
// completes in that cycle (there is no ready). MEMC_RAM_DATA_R is valid combinationally while
// MEMC_RAM_ADDR is stable. INTC_IRQ stays high until INTC_IACK is sampled, and INTC_IEND closes the service.
interface serial_tx_controller_if;
  logic        MEMC_RAM_ENABLE;
  logic        MEMC_RAM_WRITE;
  logic [15:0] MEMC_RAM_ADDR;
  logic [15:0] MEMC_RAM_DATA_R;
  logic [15:0] MEMC_RAM_DATA_W;
  logic        INTC_IRQ;
  logic        INTC_IACK;
  logic        INTC_IEND;

  modport master (
    output MEMC_RAM_ENABLE, MEMC_RAM_WRITE, MEMC_RAM_ADDR, MEMC_RAM_DATA_W, INTC_IACK, INTC_IEND,
    input  MEMC_RAM_DATA_R, INTC_IRQ
  );

  modport slave (
    input  MEMC_RAM_ENABLE, MEMC_RAM_WRITE, MEMC_RAM_ADDR, MEMC_RAM_DATA_W, INTC_IACK, INTC_IEND,
    output MEMC_RAM_DATA_R, INTC_IRQ
  );
endinterface

// File: rtl/serial_tx_controller.sv
// Byte queue plus 8N1 serial shifter with a drain interrupt.
// The interrupt FSM is built only when SERIAL_TX_IRQ_EN is defined; otherwise INTC_IRQ is tied low.
module serial_tx_controller #(
  parameter int CLKS_PER_BIT = 434,
  parameter int FIFO_DEPTH   = 4
) (
  input  logic                  CLK,
  input  logic                  RESET,
  serial_tx_controller_if.slave bus,
  output logic                  OUT_SERIAL_TX,
  output logic [1:0]            dbg_tx_state,
  output logic [1:0]            dbg_irq_state
);
  localparam int CW = $clog2(CLKS_PER_BIT);
  localparam int PW = $clog2(FIFO_DEPTH);
  localparam int NW = PW + 1;
  localparam logic [CW-1:0] BIT_LAST = CW'(CLKS_PER_BIT - 1);
  localparam logic [NW-1:0] DEPTH_N  = NW'(FIFO_DEPTH);

  typedef enum logic [1:0] {TX_IDLE = 2'd0, TX_START = 2'd1, TX_DATA = 2'd2, TX_STOP = 2'd3} tx_state_e;

  logic [7:0]    fifo_q [FIFO_DEPTH];
  logic [7:0]    fifo_d [FIFO_DEPTH];
  logic [PW-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [NW-1:0] count_q, count_d;
  logic          ovf_q, ovf_d;
  tx_state_e     tx_state_q, tx_state_d;
  logic [CW-1:0] bit_cnt_q, bit_cnt_d;
  logic [2:0]    bit_idx_q, bit_idx_d;
  logic [7:0]    shift_q, shift_d;
  logic          tx_q, tx_d;

  logic full, empty, busy, data_wr, stat_wr, push, pop, drain;
  logic [3:0] count4;

  always_comb begin
    full    = (count_q == DEPTH_N);
    empty   = (count_q == '0);
    busy    = (tx_state_q != TX_IDLE);
    count4  = 4'(count_q);
    data_wr = bus.MEMC_RAM_ENABLE & bus.MEMC_RAM_WRITE & ~bus.MEMC_RAM_ADDR[0];
    stat_wr = bus.MEMC_RAM_ENABLE & bus.MEMC_RAM_WRITE &  bus.MEMC_RAM_ADDR[0];
    // Fullness uses the registered count, so a write while full is lost even if a pop happens now.
    push    = data_wr & ~full;
  end

  always_comb begin
    tx_state_d = tx_state_q;
    bit_cnt_d  = bit_cnt_q;
    bit_idx_d  = bit_idx_q;
    shift_d    = shift_q;
    pop        = 1'b0;
    drain      = 1'b0;
    case (tx_state_q)
      TX_IDLE: begin
        if (!empty) begin
          pop        = 1'b1;
          shift_d    = fifo_q[rd_ptr_q];
          bit_cnt_d  = BIT_LAST;
          tx_state_d = TX_START;
        end
      end
      TX_START: begin
        if (bit_cnt_q == '0) begin
          bit_cnt_d  = BIT_LAST;
          bit_idx_d  = 3'd0;
          tx_state_d = TX_DATA;
        end else begin
          bit_cnt_d = bit_cnt_q - 1'b1;
        end
      end
      TX_DATA: begin
        if (bit_cnt_q == '0) begin
          shift_d   = {1'b0, shift_q[7:1]};
          bit_cnt_d = BIT_LAST;
          if (bit_idx_q == 3'd7) tx_state_d = TX_STOP;
          else                   bit_idx_d  = bit_idx_q + 3'd1;
        end else begin
          bit_cnt_d = bit_cnt_q - 1'b1;
        end
      end
      default: begin
        // Last stop cycle: chain straight into the next start bit when more data is queued.
        if (bit_cnt_q == '0) begin
          if (!empty) begin
            pop        = 1'b1;
            shift_d    = fifo_q[rd_ptr_q];
            bit_cnt_d  = BIT_LAST;
            tx_state_d = TX_START;
          end else begin
            drain      = 1'b1;
            tx_state_d = TX_IDLE;
          end
        end else begin
          bit_cnt_d = bit_cnt_q - 1'b1;
        end
      end
    endcase
    case (tx_state_q)
      TX_START: tx_d = 1'b0;
      TX_DATA:  tx_d = shift_q[0];
      default:  tx_d = 1'b1;
    endcase
  end

  always_comb begin
    fifo_d = fifo_q;
    if (push) fifo_d[wr_ptr_q] = bus.MEMC_RAM_DATA_W[7:0];
    wr_ptr_d = wr_ptr_q + PW'(push);
    rd_ptr_d = rd_ptr_q + PW'(pop);
    count_d  = count_q + NW'(push) - NW'(pop);
    ovf_d    = ovf_q;
    if (stat_wr && bus.MEMC_RAM_DATA_W[3]) ovf_d = 1'b0;
    if (data_wr && full)                   ovf_d = 1'b1;
  end

  always_ff @(posedge CLK) begin
    fifo_q <= fifo_d;
    if (RESET) begin
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      count_q    <= '0;
      ovf_q      <= 1'b0;
      tx_state_q <= TX_IDLE;
      bit_cnt_q  <= '0;
      bit_idx_q  <= 3'd0;
      shift_q    <= 8'h00;
      tx_q       <= 1'b1;
    end else begin
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      count_q    <= count_d;
      ovf_q      <= ovf_d;
      tx_state_q <= tx_state_d;
      bit_cnt_q  <= bit_cnt_d;
      bit_idx_q  <= bit_idx_d;
      shift_q    <= shift_d;
      tx_q       <= tx_d;
    end
  end

  assign OUT_SERIAL_TX       = tx_q;
  assign dbg_tx_state        = tx_state_q;
  assign bus.MEMC_RAM_DATA_R = bus.MEMC_RAM_ADDR[0] ? {8'h00, count4, ovf_q, busy, empty, full} : 16'h0000;

  logic unused_bus;
  assign unused_bus = &{1'b0, bus.MEMC_RAM_ADDR[15:1], bus.MEMC_RAM_DATA_W[15:8]};

`ifdef SERIAL_TX_IRQ_EN
  typedef enum logic [1:0] {IRQ_IDLE = 2'd0, IRQ_REQ = 2'd1, IRQ_WAIT_END = 2'd2} irq_state_e;

  irq_state_e irq_state_q, irq_state_d;
  logic       pend_q, pend_d, irq_q, irq_d;

  always_comb begin
    irq_state_d = irq_state_q;
    // Drains that arrive while an interrupt is outstanding collapse into one pending request.
    pend_d      = pend_q | (drain & (irq_state_q != IRQ_IDLE));
    case (irq_state_q)
      IRQ_IDLE:     if (drain) irq_state_d = IRQ_REQ;
      IRQ_REQ:      if (bus.INTC_IACK) irq_state_d = IRQ_WAIT_END;
      IRQ_WAIT_END: begin
        if (bus.INTC_IEND) begin
          if (pend_d) begin
            irq_state_d = IRQ_REQ;
            pend_d      = 1'b0;
          end else begin
            irq_state_d = IRQ_IDLE;
          end
        end
      end
      default:      irq_state_d = IRQ_IDLE;
    endcase
    irq_d = (irq_state_q == IRQ_REQ);
  end

  always_ff @(posedge CLK) begin
    if (RESET) begin
      irq_state_q <= IRQ_IDLE;
      pend_q      <= 1'b0;
      irq_q       <= 1'b0;
    end else begin
      irq_state_q <= irq_state_d;
      pend_q      <= pend_d;
      irq_q       <= irq_d;
    end
  end

  assign bus.INTC_IRQ  = irq_q;
  assign dbg_irq_state = irq_state_q;
`else
  logic unused_intc;
  assign unused_intc   = &{1'b0, bus.INTC_IACK, bus.INTC_IEND, drain};
  assign bus.INTC_IRQ  = 1'b0;
  assign dbg_irq_state = 2'b00;
`endif
endmodule
